kgp_alu_cmd_issuer: RTL and testbench

//  Sequential front end for the combinational KGP_ALU. It holds an 8x8-bit register bank and

---
 rtl/kgp_alu_pkg.sv | 36 +++
 rtl/kgp_alu_cmd_issuer_if.sv | 34 +++
 rtl/kgp_reg_bank.sv | 34 +++
 rtl/kgp_alu_cmd_issuer.sv | 103 ++++++++++
 tb/tb_kgp_alu_cmd_issuer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP_ALU command issuer: opcodes, command word
// field positions and issuer FSM state encodings.
package kgp_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_HAM = 4'b1111;

  localparam int CMD_OP_MSB = 31;
  localparam int CMD_OP_LSB = 28;
  localparam int CMD_A_MSB  = 15;
  localparam int CMD_A_LSB  = 8;
  localparam int CMD_B_MSB  = 7;
  localparam int CMD_B_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Bits [27:16] are reserved and always zero.
  function automatic logic [31:0] make_cmd(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [31:0] cmd;
    cmd = '0;
    cmd[CMD_OP_MSB:CMD_OP_LSB] = op;
    cmd[CMD_A_MSB:CMD_A_LSB]   = a;
    cmd[CMD_B_MSB:CMD_B_LSB]   = b;
    return cmd;
  endfunction

endpackage

// File: rtl/kgp_alu_cmd_issuer_if.sv
// Instruction, preload, ALU, completion and debug signals of the issuer.
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
// the source holds in_valid and the payload stable until that edge.
interface kgp_alu_cmd_issuer_if #(parameter int ADDR_W = 3);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_rs;
  logic [ADDR_W-1:0] in_rt;
  logic [ADDR_W-1:0] in_rd;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic [31:0]       alu_command;
  logic [7:0]        alu_z;
  logic              done_valid;
  logic [ADDR_W-1:0] done_rd;
  logic [7:0]        done_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  kgp_alu_pkg::state_t state;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, ld_en, ld_addr, ld_data, alu_z, rd_addr,
    input  in_ready, alu_command, done_valid, done_rd, done_data, rd_data, state
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, ld_en, ld_addr, ld_data, alu_z, rd_addr,
    output in_ready, alu_command, done_valid, done_rd, done_data, rd_data, state
  );

endinterface

// File: rtl/kgp_reg_bank.sv
// NREGS x 8-bit register bank: one synchronous write port, three
// asynchronous read ports (operand A, operand B, debug).
module kgp_reg_bank #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [7:0]        ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [7:0]        rb_data,
  input  logic [ADDR_W-1:0] rc_addr,
  output logic [7:0]        rc_data
);

  logic [7:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
  assign rc_data = regs[rc_addr];

endmodule

// File: rtl/kgp_alu_cmd_issuer.sv
// Register-to-register issuer for KGP_ALU: accepts (op, rs, rt, rd), drives the
// command word, waits SETTLE cycles for z, then writes z back to rd.
module kgp_alu_cmd_issuer
  import kgp_alu_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  kgp_alu_cmd_issuer_if.slave   bus
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  logic [7:0]        a_data;
  logic [7:0]        b_data;
  logic              wb_en;
  logic              ld_ok;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_waddr;
  logic [7:0]        bank_wdata;

  assign bus.in_ready = (state == ST_IDLE);
  assign bus.state    = state;

  // Loads and write-backs never collide: loads only in IDLE, write-back only in WAIT.
  assign wb_en      = (state == ST_WAIT) && (cnt == CNT_W'(1));
  assign ld_ok      = (state == ST_IDLE) && bus.ld_en;
  assign bank_we    = wb_en || ld_ok;
  assign bank_waddr = wb_en ? rd_q : bus.ld_addr;
  assign bank_wdata = wb_en ? bus.alu_z : bus.ld_data;

  kgp_reg_bank #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bank_we),
    .waddr   (bank_waddr),
    .wdata   (bank_wdata),
    .ra_addr (rs_q),
    .ra_data (a_data),
    .rb_addr (rt_q),
    .rb_data (b_data),
    .rc_addr (bus.rd_addr),
    .rc_data (bus.rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      op_q            <= '0;
      rs_q            <= '0;
      rt_q            <= '0;
      rd_q            <= '0;
      bus.alu_command <= '0;
      bus.done_valid  <= 1'b0;
      bus.done_rd     <= '0;
      bus.done_data   <= '0;
    end else begin
      bus.done_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.in_op;
            rs_q  <= bus.in_rs;
            rt_q  <= bus.in_rt;
            rd_q  <= bus.in_rd;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Operands come from the bank as it stands now, so a same-cycle load is seen.
          bus.alu_command <= make_cmd(op_q, a_data, b_data);
          cnt             <= CNT_W'(SETTLE);
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            bus.done_valid <= 1'b1;
            bus.done_rd    <= rd_q;
            bus.done_data  <= bus.alu_z;
            state          <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kgp_alu_cmd_issuer.sv
// Directed bench for kgp_alu_cmd_issuer with a behavioural KGP_ALU model on
// alu_z; one instance with SETTLE=1 and one with SETTLE=3.
module tb_kgp_alu_cmd_issuer;
  import kgp_alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  kgp_alu_cmd_issuer_if #(.ADDR_W(3)) b1 ();
  kgp_alu_cmd_issuer_if #(.ADDR_W(3)) b3 ();

  kgp_alu_cmd_issuer #(.NREGS(8), .ADDR_W(3), .SETTLE(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (b1.slave)
  );
  kgp_alu_cmd_issuer #(.NREGS(8), .ADDR_W(3), .SETTLE(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .bus (b3.slave)
  );

  function automatic logic [7:0] alu_model(input logic [31:0] cmd);
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    a = cmd[15:8];
    b = cmd[7:0];
    p = a * b;
    case (cmd[31:28])
      OP_ADD:  return a + b;
      OP_MUL:  return p[7:0];
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[2:0];
      OP_HAM:  return 8'($countones(a ^ b));
      default: return 8'h00;
    endcase
  endfunction

  assign b1.alu_z = alu_model(b1.alu_command);
  assign b3.alu_z = alu_model(b3.alu_command);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load1(input logic [2:0] addr, input logic [7:0] data);
    b1.ld_en = 1'b1; b1.ld_addr = addr; b1.ld_data = data;
    tick();
    b1.ld_en = 1'b0;
  endtask

  task automatic load3(input logic [2:0] addr, input logic [7:0] data);
    b3.ld_en = 1'b1; b3.ld_addr = addr; b3.ld_data = data;
    tick();
    b3.ld_en = 1'b0;
  endtask

  task automatic rd1(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    b1.rd_addr = addr;
    #1;
    chk(tag, 32'(b1.rd_data), 32'(exp));
  endtask

  // Single instruction on the SETTLE=1 issuer, checked cycle by cycle.
  task automatic run1(input string tag, input logic [3:0] op, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [2:0] rd,
                      input logic [31:0] exp_cmd, input logic [7:0] exp_z);
    chk({tag, "_ready_idle"}, 32'(b1.in_ready), 32'd1);
    b1.in_valid = 1'b1; b1.in_op = op; b1.in_rs = rs; b1.in_rt = rt; b1.in_rd = rd;
    tick();
    b1.in_valid = 1'b0;
    chk({tag, "_ready_busy"}, 32'(b1.in_ready), 32'd0);
    tick();
    chk({tag, "_cmd"}, b1.alu_command, exp_cmd);
    chk({tag, "_done_early"}, 32'(b1.done_valid), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(b1.done_valid), 32'd1);
    chk({tag, "_done_rd"}, 32'(b1.done_rd), 32'(rd));
    chk({tag, "_done_data"}, 32'(b1.done_data), 32'(exp_z));
    tick();
    chk({tag, "_done_pulse"}, 32'(b1.done_valid), 32'd0);
    chk({tag, "_done_hold"}, 32'(b1.done_data), 32'(exp_z));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    {b1.in_valid, b1.in_op, b1.in_rs, b1.in_rt, b1.in_rd} = '0;
    {b1.ld_en, b1.ld_addr, b1.ld_data, b1.rd_addr} = '0;
    {b3.in_valid, b3.in_op, b3.in_rs, b3.in_rt, b3.in_rd} = '0;
    {b3.ld_en, b3.ld_addr, b3.ld_data, b3.rd_addr} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    chk("rst_ready", 32'(b1.in_ready), 32'd1);
    chk("rst_cmd", b1.alu_command, 32'h0);
    chk("rst_done", 32'(b1.done_valid), 32'd0);
    chk("rst_done_data", 32'(b1.done_data), 32'h0);
    rd1("rst_r5", 3'd5, 8'h00);

    // Test 1: ADD r3 = r2 + r1
    load1(3'd1, 8'h01);
    load1(3'd2, 8'h03);
    run1("add", OP_ADD, 3'd2, 3'd1, 3'd3, 32'h0000_0301, 8'h04);
    rd1("add_r3", 3'd3, 8'h04);

    // Test 2: XOR r6 = r4 ^ r5
    load1(3'd4, 8'h23);
    load1(3'd5, 8'h0A);
    run1("xor", OP_XOR, 3'd4, 3'd5, 3'd6, 32'h6000_230A, 8'h29);
    rd1("xor_r6", 3'd6, 8'h29);

    // Test 3: back-to-back, in_valid held; second op reads the first's result
    b1.in_valid = 1'b1; b1.in_op = OP_ADD; b1.in_rs = 3'd1; b1.in_rt = 3'd2; b1.in_rd = 3'd7;
    tick();
    b1.in_op = OP_XOR; b1.in_rs = 3'd7; b1.in_rt = 3'd4; b1.in_rd = 3'd0;
    chk("b2b_busy1", 32'(b1.in_ready), 32'd0);
    tick();
    chk("b2b_busy2", 32'(b1.in_ready), 32'd0);
    chk("b2b_cmd1", b1.alu_command, 32'h0000_0103);
    tick();
    chk("b2b_ready", 32'(b1.in_ready), 32'd1);
    chk("b2b_done1", 32'(b1.done_valid), 32'd1);
    chk("b2b_rd1", 32'(b1.done_rd), 32'd7);
    chk("b2b_data1", 32'(b1.done_data), 32'h04);
    tick();
    b1.in_valid = 1'b0;
    chk("b2b_accept2", 32'(b1.in_ready), 32'd0);
    tick();
    chk("b2b_cmd2", b1.alu_command, 32'h6000_0423);
    tick();
    chk("b2b_done2", 32'(b1.done_valid), 32'd1);
    chk("b2b_rd2", 32'(b1.done_rd), 32'd0);
    chk("b2b_data2", 32'(b1.done_data), 32'h27);
    rd1("b2b_r0", 3'd0, 8'h27);

    // Test 4: load r1 and accept r1 = r1 + r1 in the same IDLE cycle
    b1.ld_en = 1'b1; b1.ld_addr = 3'd1; b1.ld_data = 8'h05;
    b1.in_valid = 1'b1; b1.in_op = OP_ADD; b1.in_rs = 3'd1; b1.in_rt = 3'd1; b1.in_rd = 3'd1;
    tick();
    b1.ld_en = 1'b0; b1.in_valid = 1'b0;
    tick();
    chk("alias_cmd", b1.alu_command, 32'h0000_0505);
    tick();
    chk("alias_done", 32'(b1.done_valid), 32'd1);
    chk("alias_data", 32'(b1.done_data), 32'h0A);
    rd1("alias_r1", 3'd1, 8'h0A);

    // Test 5: SETTLE=3, ld_en during WAIT ignored
    load3(3'd2, 8'h11);
    load3(3'd3, 8'h22);
    b3.in_valid = 1'b1; b3.in_op = OP_ADD; b3.in_rs = 3'd2; b3.in_rt = 3'd3; b3.in_rd = 3'd4;
    tick();
    b3.in_valid = 1'b0;
    tick();
    chk("s3_cmd", b3.alu_command, 32'h0000_1122);
    b3.ld_en = 1'b1; b3.ld_addr = 3'd2; b3.ld_data = 8'hFF;
    tick();
    chk("s3_done_c2", 32'(b3.done_valid), 32'd0);
    tick();
    chk("s3_done_c3", 32'(b3.done_valid), 32'd0);
    b3.ld_en = 1'b0;
    tick();
    chk("s3_done_c4", 32'(b3.done_valid), 32'd1);
    chk("s3_data", 32'(b3.done_data), 32'h33);
    b3.rd_addr = 3'd2;
    #1;
    chk("s3_ld_ignored", 32'(b3.rd_data), 32'h11);
    b3.rd_addr = 3'd4;
    #1;
    chk("s3_r4", 32'(b3.rd_data), 32'h33);

    // Test 6: reset during WAIT drops the write-back
    tick();
    b1.in_valid = 1'b1; b1.in_op = OP_ADD; b1.in_rs = 3'd5; b1.in_rt = 3'd5; b1.in_rd = 3'd2;
    tick();
    b1.in_valid = 1'b0;
    tick();
    chk("rstw_cmd", b1.alu_command, 32'h0000_0A0A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_cmd0", b1.alu_command, 32'h0);
    chk("rstw_done0", 32'(b1.done_valid), 32'd0);
    chk("rstw_rd0", 32'(b1.done_rd), 32'd0);
    chk("rstw_data0", 32'(b1.done_data), 32'h0);
    chk("rstw_s3_data0", 32'(b3.done_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rstw_ready", 32'(b1.in_ready), 32'd1);
    chk("rstw_no_wb", 32'(b1.done_valid), 32'd0);
    tick();
    chk("rstw_no_wb2", 32'(b1.done_valid), 32'd0);
    rd1("rstw_r2", 3'd2, 8'h00);
    rd1("rstw_r5", 3'd5, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
